dmem_responder: RTL

//  Data-memory responder (target) for the RV32 core's load/store request interface.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 types for the data-memory path: access sizes, responder FSM states
// and lane geometry constants.
package riscv_pkg;

  localparam int LANE_W      = 8;   // bits per byte lane
  localparam int CNT_W       = 4;   // latency counter width, covers LATENCY 1..15
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2,
    MemRsvd = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    DmemIdle = 2'd0,
    DmemWait = 2'd1,
    DmemResp = 2'd2
  } dmem_state_e;

  // True when the access size is one the core may legally issue.
  function automatic logic size_legal(input mem_size_e size);
    return size != MemRsvd;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads and stores: builds write byte-enables and the
// lane-shifted store word, extracts and extends load data, and flags misalignment.
module dmem_lane_align
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_LANES = XLEN / LANE_W,
  parameter int LW        = $clog2(NUM_LANES)
) (
  input  mem_size_e                            size,
  input  logic [LW-1:0]                        lane,
  input  logic                                 is_unsigned,
  input  logic [XLEN-1:0]                      wdata,
  input  logic [XLEN-1:0]                      rword,
  output logic [NUM_LANES-1:0]                 be,
  output logic [NUM_LANES-1:0][LANE_W-1:0]     wword,
  output logic [XLEN-1:0]                      rdata,
  output logic                                 misalign
);

  logic [NUM_LANES-1:0][LANE_W-1:0]     rbytes;
  logic [NUM_LANES/2-1:0][2*LANE_W-1:0] rhalves;
  logic [LANE_W-1:0]                    rbyte;
  logic [2*LANE_W-1:0]                  rhalf;

  // Per-lane enable and data: a byte store replicates wdata[7:0] to every lane,
  // a half store replicates wdata[15:0] to each half, and the enable picks the target.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be[i] = (size == MemWord)
                 | ((size == MemHalf) && (lane[LW-1:1] == (LW-1)'(i / 2)))
                 | ((size == MemByte) && (lane == LW'(i)));
    assign wword[i] = (size == MemWord) ? wdata[LANE_W*i +: LANE_W]
                    : (size == MemHalf) ? wdata[LANE_W*(i % 2) +: LANE_W]
                    :                     wdata[LANE_W-1:0];
  end

  assign rbytes  = rword;
  assign rhalves = rword;
  assign rbyte   = rbytes[lane];
  assign rhalf   = rhalves[lane[LW-1:1]];

  assign misalign = ((size == MemHalf) && lane[0])
                  | ((size == MemWord) && (lane != '0));

  // Load extraction; word loads ignore is_unsigned.
  always_comb begin
    rdata = '0;
    case (size)
      MemByte: rdata = {{(XLEN-LANE_W){~is_unsigned & rbyte[LANE_W-1]}}, rbyte};
      MemHalf: rdata = {{(XLEN-2*LANE_W){~is_unsigned & rhalf[2*LANE_W-1]}}, rhalf};
      MemWord: rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 LSU: single-outstanding valid/ready request,
// fixed programmable response latency, word-organised RAM with byte-lane writes,
// and a side-effect-free combinational debug read port.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              MEM_WORDS = 2048,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              LATENCY   = 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  localparam int              NUM_LANES = XLEN / LANE_W;
  localparam int              LW        = $clog2(NUM_LANES);
  localparam int              AW        = $clog2(MEM_WORDS);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * NUM_LANES);
  localparam logic [XLEN-1:0] MEM_LIM   = XLEN'(MEM_WORDS);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [MEM_WORDS];

  dmem_state_e      state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [XLEN-1:0]  rdata_q;
  logic             err_q;

  mem_size_e                        size;
  logic [XLEN-1:0]                  off;
  logic [AW-1:0]                    idx;
  logic [LW-1:0]                    lane;
  logic                             accept, misalign, err, wr_en;
  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] wword;
  logic [XLEN-1:0]                  rword, ld_data;

  // Offsets below BASE_ADDR wrap to huge values and fall out of range naturally.
  assign size   = mem_size_e'(req_size_i);
  assign off    = req_addr_i - BASE_ADDR;
  assign idx    = off[AW+LW-1:LW];
  assign lane   = off[LW-1:0];
  assign accept = (state == DmemIdle) && req_valid_i;
  assign err    = !size_legal(size) || misalign || (off >= MEM_BYTES);
  assign wr_en  = accept && req_we_i && !err;
  assign rword  = mem[idx];

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .size        (size),
    .lane        (lane),
    .is_unsigned (req_unsigned_i),
    .wdata       (req_wdata_i),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data),
    .misalign    (misalign)
  );

  // RAM write at the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[idx][i] <= wword[i];
      end
    end
  end

  assign dbg_data_o = (dbg_addr_i < MEM_LIM) ? mem[dbg_addr_i[AW-1:0]] : '0;

  // State and latency counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= DmemIdle;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state and handshake outputs; the handshake cycle in RESP never accepts.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      DmemIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          count_nxt = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? DmemResp : DmemWait;
        end
      end
      DmemWait: begin
        count_nxt = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_nxt = DmemResp;
      end
      DmemResp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = DmemIdle;
      end
      default: state_nxt = DmemIdle;
    endcase
  end

  // Response is captured at accept so it stays stable however long the stall.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (err || req_we_i) ? '0 : ld_data;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
